// File: rtl/mac_dot_sequencer_pkg.sv
// Shared types for the dot-product sequencer: operand word format, FSM states
// and the fixed drain depth between the last operand and the MAC result.
package mac_dot_sequencer_pkg;

    localparam int SINGLE       = 32;
    localparam int DRAIN_CYCLES = 2;

    typedef struct packed {
        logic [SINGLE-1:0] value;
        logic              valid;
    } scalar_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        OUT
    } seq_state_t;

endpackage

// File: rtl/mac_dot_sequencer_operand_pair_join.sv
// Joins the data and weight streams into pairs and registers each fired pair
// as a Scalar operand for the MAC; outputs are zero in any cycle without a pair.
module operand_pair_join
    import mac_dot_sequencer_pkg::*;
#(
    parameter int DATA_W = SINGLE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_a_valid,
    input  logic [DATA_W-1:0] i_a_value,
    input  logic              i_b_valid,
    input  logic [DATA_W-1:0] i_b_value,
    output logic              o_a_ready,
    output logic              o_b_ready,
    output logic              o_fire,
    output scalar_t           o_data,
    output scalar_t           o_weight
);

    logic    w_fire;
    scalar_t r_data;
    scalar_t r_weight;

    // Each side is ready only when the other side is offering, so a lone
    // element is never consumed.
    assign w_fire    = i_en & i_a_valid & i_b_valid;
    assign o_a_ready = i_en & i_b_valid;
    assign o_b_ready = i_en & i_a_valid;
    assign o_fire    = w_fire;
    assign o_data    = r_data;
    assign o_weight  = r_weight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_weight <= '0;
        end else if (w_fire) begin
            r_data   <= '{value: i_a_value, valid: 1'b1};
            r_weight <= '{value: i_b_value, valid: 1'b1};
        end else begin
            r_data   <= '0;
            r_weight <= '0;
        end
    end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Dot-product command sequencer feeding one MAC: clears it, streams N operand
// pairs, waits for the accumulator to settle and returns the sum.
module mac_dot_sequencer
    import mac_dot_sequencer_pkg::*;
#(
    parameter int LEN_W  = 16,
    parameter int DATA_W = SINGLE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] a_value,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [DATA_W-1:0] b_value,
    output logic              mac_clear,
    output scalar_t           mac_data,
    output scalar_t           mac_weight,
    input  logic [DATA_W-1:0] mac_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy
);

    seq_state_t        r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_pair_cnt;
    logic [1:0]        r_drain_cnt;
    logic              r_mac_clear;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic              w_stream_en;
    logic              w_fire;

    assign w_stream_en = (r_state == STREAM);
    assign cmd_ready   = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign mac_clear   = r_mac_clear;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;

    operand_pair_join #(
        .DATA_W (DATA_W)
    ) u_join (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_stream_en),
        .i_a_valid (a_valid),
        .i_a_value (a_value),
        .i_b_valid (b_valid),
        .i_b_value (b_value),
        .o_a_ready (a_ready),
        .o_b_ready (b_ready),
        .o_fire    (w_fire),
        .o_data    (mac_data),
        .o_weight  (mac_weight)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_pair_cnt  <= '0;
            r_drain_cnt <= '0;
            r_mac_clear <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_mac_clear <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_len       <= cmd_len;
                        r_pair_cnt  <= '0;
                        r_mac_clear <= 1'b1;
                        r_state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_drain_cnt <= '0;
                    r_state     <= (r_len == '0) ? DRAIN : STREAM;
                end
                STREAM: begin
                    if (w_fire) begin
                        r_pair_cnt <= r_pair_cnt + LEN_W'(1);
                        if (r_pair_cnt == r_len - LEN_W'(1)) begin
                            r_drain_cnt <= '0;
                            r_state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Covers the operand register stage plus the MAC update.
                    if (r_drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                        r_res_data  <= mac_out;
                        r_res_valid <= 1'b1;
                        r_state     <= OUT;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
- Control stage directly upstream of the MAC accumulator.
- Accepts a dot-product command of length N, pairs the data and weight element streams, and feeds them to the MAC.
- Drives the MAC clear, waits for the accumulation to settle, then returns the 32-bit single-precision sum on a valid/ready result port.
- One MAC per instance; an array of MACs uses one instance per lane.

Parameters:
- LEN_W, 16, width of the command length field; maximum N = 2^LEN_W - 1.
- DATA_W, 32, single-precision word width; must match the shared SINGLE width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer idle and able to accept a command
- cmd_len  in  LEN_W  number of element pairs N
- a_valid  in  1  data element offered
- a_ready  out  1  data element consumed
- a_value  in  DATA_W  data element
- b_valid  in  1  weight element offered
- b_ready  out  1  weight element consumed
- b_value  in  DATA_W  weight element
- mac_clear  out  1  one-cycle clear to the MAC
- mac_data  out  Scalar  data operand {value, valid} to the MAC
- mac_weight  out  Scalar  weight operand {value, valid} to the MAC
- mac_out  in  DATA_W  MAC accumulator value
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  DATA_W  dot-product result
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values:
  - state = IDLE.
  - mac_clear, mac_data, mac_weight, res_valid, res_data, pair count, drain count = 0.
  - cmd_ready = 1 once out of reset.
- Registering: all MAC-side outputs and res_* are registered; cmd_ready, a_ready, b_ready are combinational from state and the valids.

States:
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready at edge E0: latch cmd_len and go to CLEAR.
- CLEAR:
  - mac_clear = 1 during cycle E0+1 only; no operand is valid in that cycle.
  - If the latched N == 0, go to DRAIN; otherwise go to STREAM.
- STREAM:
  - Pair handshake: a_ready = b_valid, b_ready = a_valid, so a pair fires only when both are valid. A lone valid on one side is never consumed.
  - A pair fired in cycle c makes mac_data.valid = mac_weight.valid = 1 in cycle c+1, carrying the fired values.
  - In every other cycle both valids are 0 and both values are 0.
  - The pair counter increments on each fire. The fire with count == N-1 moves the state to DRAIN.
  - No pair is accepted beyond N.
- DRAIN:
  - Fixed 2 cycles, covering the operand register plus the MAC update.
  - At the end of the second cycle, res_data <= mac_out; go to OUT.
  - Timing: if the last pair fires in cycle L, res_valid rises in cycle L+3.
  - For N == 0, res_valid rises in cycle E0+4 with res_data = 0x00000000.
- OUT:
  - res_valid held at 1 and res_data stable until res_ready.
  - On res_valid & res_ready: res_valid <= 0 and go to IDLE, so cmd_ready = 1 in the next cycle.
  - Back-to-back: a new command can be accepted the cycle after the result handshake. No overlap of commands.

Other rules:
- Arithmetic: none locally. Values pass through unmodified; the pair counter is LEN_W bits and never wraps, since it is bounded by N.
- Reset mid-operation: everything returns to the reset values immediately. Partially streamed pairs are discarded, no result is produced, and the MAC is cleared again by the next command.
- Simultaneous events:
  - cmd_valid in non-IDLE states is ignored (cmd_ready = 0).
  - a_valid/b_valid outside STREAM is not consumed.

Decomposition:
- Shared types package:
  - Scalar struct {logic [DATA_W-1:0] value; logic valid}.
  - SINGLE width constant.
  - Sequencer state enum {IDLE, CLEAR, STREAM, DRAIN, OUT}.
  - DRAIN_CYCLES = 2.
- Sub-module operand_pair_join: holds the two-stream join plus the registered Scalar outputs. It is driven by an enable from the sequencer FSM.

Test Plan:
- N=3, a = {1.0, 2.0, 3.0} (0x3F800000, 0x40000000, 0x40400000), b = {4.0, 5.0, 6.0}, both streams always valid, with a behavioural MAC model -> mac_clear one pulse at E0+1; three operand-valid cycles; res_data = 32.0 (0x42000000); res_valid at L+3.
- N=0 -> no a_ready/b_ready ever; mac_clear one pulse; res_data = 0x00000000 at E0+4.
- N=2 with b_valid arriving 3 cycles after a_valid -> a not consumed until b is valid; pairs fire together; result 1·4 + 2·5 = 14.0 (0x41600000).
- res_ready held low for 5 cycles, then a second command offered during OUT -> res_valid/res_data stable; cmd_ready = 0 until the cycle after the result handshake; the second command then runs correctly from a fresh clear.
- rst_n asserted during STREAM after 1 of 4 pairs, then a new N=1 command (2.0 × 3.0) -> all outputs 0 during reset; new result 6.0 (0x40C00000) with no stale contribution.
- Streams keep offering elements after the N-th pair -> no extra a_ready/b_ready; mac_*.valid stays 0 in DRAIN and OUT.
